// File: rtl/conv_pkg.sv
// Shared types and sizing constants for the convolution frame sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int N_ACT      = 16;
  localparam int N_FILT     = 9;
  localparam int N_RES      = 4;
  localparam int N_OPS      = N_ACT + N_FILT;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/conv_result_drain.sv
// Four-entry result register that serializes c11, c12, c21, c22 over a
// valid/ready handshake, flagging the final byte with out_last.
module conv_result_drain
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [N_RES*DATA_W-1:0] load_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic                    last_accept
);

  localparam logic [1:0] IDX_LAST = 2'(N_RES - 1);

  logic [DATA_W-1:0] res_q [N_RES];
  logic [DATA_W-1:0] res_d [N_RES];
  logic [1:0]        idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  assign last_accept = valid_q && out_ready && (idx_q == IDX_LAST);

  // NOTE: every signal assigned here gets a default first, so no latches are inferred.
  always_comb begin
    res_d   = res_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load) begin
      for (int i = 0; i < N_RES; i++) begin
        res_d[i] = load_data[i*DATA_W +: DATA_W];
      end
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == IDX_LAST) begin
        valid_d = 1'b0;
      end
    end
    // Outputs are registered from the next index so they stay stable under backpressure.
    data_d = res_d[idx_d];
    last_d = valid_d && (idx_d == IDX_LAST);
  end

  // NOTE: state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the small result register file is reset because its zero value is observable.
      res_q   <= '{default: '0};
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      res_q   <= res_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/conv_frame_sequencer.sv
// Initiator-side sequencer: loads 25 operand bytes, runs the single-PE array
// with a timeout guard, then drains the four result bytes.
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RUN_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic [N_ACT*DATA_W-1:0]  a_flat,
  output logic [N_FILT*DATA_W-1:0] b_flat,
  output logic                     active_single,
  input  logic                     done_single,
  input  logic [N_RES*DATA_W-1:0]  c_flat,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     err_timeout
);

  localparam int               TMO_W    = $clog2(RUN_TIMEOUT);
  localparam logic [4:0]       CNT_LAST = 5'(N_OPS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RUN_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              in_ready_q, in_ready_d;
  logic              active_q, active_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] act_q  [N_ACT];
  logic [DATA_W-1:0] act_d  [N_ACT];
  logic [DATA_W-1:0] filt_q [N_FILT];
  logic [DATA_W-1:0] filt_d [N_FILT];

  logic                    drain_load;
  logic [N_RES*DATA_W-1:0] drain_data;
  logic                    drain_last;
  logic [3:0]              filt_idx;

  assign filt_idx = 4'(cnt_q - 5'(N_ACT));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    in_ready_d = in_ready_q;
    active_d   = active_q;
    err_d      = err_q;
    act_d      = act_q;
    filt_d     = filt_q;
    drain_load = 1'b0;
    drain_data = c_flat;

    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          if (cnt_q < 5'(N_ACT)) begin
            act_d[cnt_q[3:0]] = in_data;
          end else begin
            filt_d[filt_idx] = in_data;
          end
          if (cnt_q == CNT_LAST) begin
            state_d    = RUN;
            cnt_d      = '0;
            tmo_d      = '0;
            in_ready_d = 1'b0;
            active_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      RUN: begin
        tmo_d = tmo_q + 1'b1;
        // A completion in the final timeout cycle still counts as success.
        if (done_single) begin
          drain_load = 1'b1;
          active_d   = 1'b0;
          err_d      = 1'b0;
          state_d    = DRAIN;
        end else if (tmo_q == TMO_LAST) begin
          drain_load = 1'b1;
          drain_data = '0;
          active_d   = 1'b0;
          err_d      = 1'b1;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          state_d    = LOAD;
          in_ready_d = 1'b1;
        end
      end
      default: begin
        state_d    = LOAD;
        in_ready_d = 1'b1;
        active_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      tmo_q      <= '0;
      in_ready_q <= 1'b1;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
      act_q      <= '{default: '0};
      filt_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      in_ready_q <= in_ready_d;
      active_q   <= active_d;
      err_q      <= err_d;
      act_q      <= act_d;
      filt_q     <= filt_d;
    end
  end

  for (genvar i = 0; i < N_ACT; i++) begin : g_act
    assign a_flat[i*DATA_W +: DATA_W] = act_q[i];
  end

  for (genvar i = 0; i < N_FILT; i++) begin : g_filt
    assign b_flat[i*DATA_W +: DATA_W] = filt_q[i];
  end

  assign in_ready      = in_ready_q;
  assign active_single = active_q;
  assign err_timeout   = err_q;

  conv_result_drain #(
    .DATA_W (DATA_W)
  ) u_drain (
    .clk         (clk),
    .rst         (rst),
    .load        (drain_load),
    .load_data   (drain_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .last_accept (drain_last)
  );

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Randomized scoreboard bench for conv_frame_sequencer with an array responder model.
module tb_conv_frame_sequencer;

  localparam int W  = 8;
  localparam int RT = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [W-1:0]    in_data;
  logic            in_ready;
  logic [16*W-1:0] a_flat;
  logic [9*W-1:0]  b_flat;
  logic            active_single;
  logic            done_single;
  logic [4*W-1:0]  c_flat;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic            out_ready;
  logic            err_timeout;

  conv_frame_sequencer #(.DATA_W(W), .RUN_TIMEOUT(RT)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .a_flat        (a_flat),
    .b_flat        (b_flat),
    .active_single (active_single),
    .done_single   (done_single),
    .c_flat        (c_flat),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [7:0]  frame[25];
  int          cur_delay;
  logic [31:0] cur_c;
  int          beats = 0;
  int          ready_mode = 0;
  int          hold_cnt = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  // Array responder: answers after cur_delay active cycles, checks operands and run length.
  initial begin
    bit              in_run = 0;
    int              k = 0;
    logic [127:0]    ea;
    logic [71:0]     eb;
    done_single = 1'b0;
    c_flat      = '0;
    forever begin
      @(negedge clk);
      c_flat = $urandom;
      if (rst) begin
        beats       = 0;
        in_run      = 0;
        done_single = 1'b0;
      end else begin
        if (in_valid && in_ready) beats++;
        if (active_single || out_valid) check("in_ready_busy", 128'(in_ready), 128'(0));
        if (active_single && !in_run) begin
          in_run = 1;
          k      = 0;
          for (int i = 0; i < 16; i++) ea[i*8 +: 8] = frame[i];
          for (int i = 0; i < 9; i++)  eb[i*8 +: 8] = frame[16+i];
          check("beats_before_run", 128'(beats), 128'(25));
          check("a_flat", 128'(a_flat), ea);
          check("b_flat", 128'(b_flat), 128'(eb));
          beats = 0;
        end
        if (in_run) begin
          if (active_single) begin
            if (k == cur_delay) begin
              done_single = 1'b1;
              c_flat      = cur_c;
            end
            k++;
          end else begin
            in_run      = 0;
            done_single = 1'b0;
            check("active_len", 128'(k), 128'((cur_delay <= RT-1) ? cur_delay + 1 : RT));
          end
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on each accepted byte, checks hold under stall.
  initial begin
    bit         pending = 0;
    logic [7:0] pd;
    logic       pl;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 0;
      end else if (out_valid) begin
        if (pending) check("hold_stable", {out_data, out_last}, {pd, pl});
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 128'(out_data), 128'(0));
            n_fail += (n_fail == 0 && out_data == 0) ? 1 : 0;
          end else begin
            e = exp_q.pop_front();
            check("out_data", 128'(out_data), 128'(e.d));
            check("out_last", 128'(out_last), 128'(e.l));
          end
          pending = 0;
        end else begin
          pending = 1;
          pd      = out_data;
          pl      = out_last;
        end
      end else begin
        if (pending) check("dropped_byte", 128'(out_valid), 128'(1));
        pending = 0;
      end
    end
  end

  // Downstream ready pattern: 0 always ready, 1 random, 2 stall five cycles then toggle.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(1, 0));
        default: begin
          if (out_valid && hold_cnt < 5) begin
            out_ready = 1'b0;
            hold_cnt++;
          end else if (out_valid) begin
            out_ready = ~out_ready;
          end else begin
            out_ready = 1'b0;
          end
        end
      endcase
    end
  end

  initial begin
    #200000;
    check("watchdog", 128'(0), 128'(1));
    finish_run();
  end

  task automatic drive_byte(input logic [7:0] b);
    bit acc = 0;
    int guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 300) begin
        check("in_ready_wait", 128'(0), 128'(1));
        finish_run();
      end
    end
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic run_frame(input int delay, input logic [31:0] c, input bit gaps,
                           input bit stray, input bit basic, input int mode, input bit do_reset);
    bit to;
    int guard;
    exp_t e;
    to         = (delay > RT - 1);
    ready_mode = mode;
    hold_cnt   = 0;
    for (int i = 0; i < 25; i++) frame[i] = basic ? ((i < 16) ? 8'(i + 1) : 8'd1) : 8'($urandom);
    cur_delay = delay;
    cur_c     = c;
    if (!do_reset) begin
      for (int r = 0; r < 4; r++) begin
        e.d = to ? 8'h00 : c[r*8 +: 8];
        e.l = (r == 3);
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < 25; i++) begin
      if (gaps) while ($urandom_range(1, 0) == 1) begin @(posedge clk); #1; end
      drive_byte(frame[i]);
      if (stray && i == 10) begin
        done_single = 1'b1;
        @(posedge clk);
        #1;
        done_single = 1'b0;
      end
    end
    in_valid = 1'b1;
    repeat (3) begin
      in_data = $urandom;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (do_reset) begin
      guard = 0;
      while (!active_single && guard < 100) begin @(posedge clk); #1; guard++; end
      check("reset_run_started", 128'(active_single), 128'(1));
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst_active_async", 128'(active_single), 128'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_err", 128'(err_timeout), 128'(0));
      @(posedge clk);
      #1;
    end else begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!(exp_q.size() == 0 && !out_valid && in_ready) && guard < 400);
      check("frame_complete", 128'(guard < 400), 128'(1));
      check("err_timeout", 128'(err_timeout), 128'(to));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_active", 128'(active_single), 128'(0));
    check("reset_outs", {out_valid, out_data, out_last, err_timeout}, 128'(0));
    check("reset_a_flat", 128'(a_flat), 128'(0));
    check("reset_b_flat", 128'(b_flat), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame(38, 32'h44332211, 0, 0, 1, 0, 0);
    run_frame($urandom_range(20, 0), $urandom, 1, 0, 0, 1, 0);
    run_frame(5, $urandom, 0, 0, 0, 2, 0);
    run_frame(1000, $urandom, 0, 0, 0, 0, 0);
    run_frame(RT - 1, $urandom, 0, 0, 0, 1, 0);
    run_frame(1000, $urandom, 1, 0, 0, 1, 0);
    run_frame(0, $urandom, 0, 0, 0, 0, 0);
    run_frame(1000, $urandom, 0, 0, 0, 0, 1);
    run_frame(12, $urandom, 1, 1, 0, 1, 0);
    for (int f = 0; f < 6; f++) begin
      run_frame($urandom_range(70, 0), $urandom, 1, 0, 0, 1, 0);
    end
    repeat (5) @(posedge clk);
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    finish_run();
  end

endmodule
